// File: rtl/t03_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM states, default geometry and address-field layout.
package t03_icache_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int ADDR_W             = 32;
  localparam int DATA_W             = 32;
  localparam int BYTE_OFF_W         = 2;

  localparam int DEF_NUM_LINES      = 8;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Field positions for the default geometry (8 lines x 4 words).
  localparam int DEF_OFF_LSB        = 2;
  localparam int DEF_IDX_LSB        = 4;
  localparam int DEF_TAG_LSB        = 7;
  localparam int DEF_TAG_W          = 25;

  // Tag width left over once byte, word and index bits are removed.
  function automatic int tag_width(input int num_lines, input int words_per_line);
    return ADDR_W - BYTE_OFF_W - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/t03_icache_data_array.sv
// Instruction data storage: one synchronous write port used by the
// line fill, one combinational read port used by the zero-wait hit path.
module t03_icache_data_array
  import t03_icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int IDX_W          = $clog2(NUM_LINES),
  parameter int OFF_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_line,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_line,
  input  logic [OFF_W-1:0]  rd_word,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_LINES*WORDS_PER_LINE];

  // Fill writes land one word per accepted memory beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_line, wr_word}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_line, rd_word}];

endmodule

// File: rtl/t03_icache_fetch.sv
// Direct-mapped, read-only instruction cache in front of the PC.
// Hits return in the same cycle; a miss freezes the PC while the whole
// line is fetched word by word, then one COMMIT cycle publishes the tag.
module t03_icache_fetch
  import t03_icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] miss_count
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = tag_width(NUM_LINES, WORDS_PER_LINE);
  localparam int OFF_LSB = BYTE_OFF_W;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  state_t                 state_reg, state_next;
  logic [31:OFF_LSB]      fetch_addr_reg;
  logic                   req_active_reg;
  logic [OFF_W-1:0]       fill_cnt_reg;
  logic                   flush_pending_reg;
  logic [15:0]            miss_count_reg;
  logic [NUM_LINES-1:0]   valid_reg;
  logic [TAG_W-1:0]       tag_mem [NUM_LINES];

  logic [OFF_W-1:0]       f_off;
  logic [IDX_W-1:0]       f_idx;
  logic [TAG_W-1:0]       f_tag;
  logic                   line_hit;
  logic                   lookup_miss;
  logic                   fill_we;
  logic [DATA_W-1:0]      rd_data;
  logic                   unused_byte_bits;

  // Byte offset never matters for word fetches.
  assign unused_byte_bits = &addr_in[OFF_LSB-1:0];

  assign f_off = fetch_addr_reg[IDX_LSB-1:OFF_LSB];
  assign f_idx = fetch_addr_reg[TAG_LSB-1:IDX_LSB];
  assign f_tag = fetch_addr_reg[31:TAG_LSB];

  assign line_hit    = valid_reg[f_idx] && (tag_mem[f_idx] == f_tag);
  assign lookup_miss = (state_reg == LOOKUP) && req_active_reg && !line_hit;
  assign miss_count  = miss_count_reg;

  t03_icache_data_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .OFF_W          (OFF_W)
  ) u_data (
    .clk     (clk),
    .wr_en   (fill_we),
    .wr_line (f_idx),
    .wr_word (fill_cnt_reg),
    .wr_data (mem_rdata),
    .rd_line (f_idx),
    .rd_word (f_off),
    .rd_data (rd_data)
  );

  // Next state and all outputs; mem_ack only matters while FILL drives mem_req.
  always_comb begin
    state_next  = state_reg;
    stall       = 1'b0;
    instr_valid = 1'b0;
    instr_out   = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    fill_we     = 1'b0;
    case (state_reg)
      LOOKUP: begin
        if (req_active_reg) begin
          if (line_hit) begin
            instr_valid = 1'b1;
            instr_out   = rd_data;
          end else begin
            stall      = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {f_tag, f_idx, fill_cnt_reg, 2'b00};
        if (mem_ack) begin
          fill_we = 1'b1;
          if (fill_cnt_reg == LAST_WORD) begin
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        stall      = 1'b1;
        state_next = LOOKUP;
      end
      default: state_next = LOOKUP;
    endcase
  end

  // Control state; reset abandons any fill in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= LOOKUP;
      fetch_addr_reg    <= '0;
      req_active_reg    <= 1'b0;
      fill_cnt_reg      <= '0;
      flush_pending_reg <= 1'b0;
      miss_count_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (!stall) begin
        fetch_addr_reg <= addr_in[31:OFF_LSB];
        req_active_reg <= fetch_en;
      end
      if (lookup_miss) begin
        miss_count_reg <= miss_count_reg + 16'd1;
        fill_cnt_reg   <= '0;
      end else if (fill_we) begin
        fill_cnt_reg <= fill_cnt_reg + OFF_W'(1);
      end
      // A flush seen mid-refill is deferred so the line being filled is also dropped.
      if (state_reg == FILL && flush) begin
        flush_pending_reg <= 1'b1;
      end else if (state_reg == COMMIT) begin
        flush_pending_reg <= 1'b0;
      end
    end
  end

  // Valid bits: flush clears everything; COMMIT publishes the new line unless a flush is owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (state_reg == LOOKUP && flush) begin
      valid_reg <= '0;
    end else if (state_reg == COMMIT) begin
      if (flush_pending_reg || flush) begin
        valid_reg <= '0;
      end else begin
        valid_reg[f_idx] <= 1'b1;
      end
    end
  end

  // Tag store has no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (state_reg == COMMIT) begin
      tag_mem[f_idx] <= f_tag;
    end
  end

endmodule

// File: tb/tb_t03_icache_fetch.sv
// Directed bench for the instruction cache: cold miss, hit streak,
// conflict refill, slow memory, flush in LOOKUP and mid-FILL, reset mid-FILL.
module tb_t03_icache_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_in = '0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  logic [15:0] miss_count;

  int vecs = 0;
  int errs = 0;
  int mem_lat = 0;
  logic [31:0] seen_addr[$];

  assign mem_ack = resp_ack | spur_ack;

  t03_icache_fetch #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_in     (addr_in),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  // Backing memory contents: low byte 0xA0+word, upper bits from the line address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hA0 + {30'd0, a[3:2]} + ((a & ~32'h1F) << 4);
  endfunction

  // Memory responder: acks after mem_lat waiting cycles, acts on the falling edge.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= mem_lat) begin
          resp_ack  = 1'b1;
          mem_rdata = data_of(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed 0x%0h expected 0x%0h", vecs, tag, obs, exp);
  endtask

  // Runs until stall drops, recording stalled cycles, request cycles, fill starts and addresses.
  task automatic wait_fill(output int stalls, output int req_cyc, output int n_fill);
    logic prev_req;
    stalls = 0;
    req_cyc = 0;
    n_fill = 0;
    prev_req = 1'b0;
    seen_addr.delete();
    for (int i = 0; i < 400 && stall; i++) begin
      stalls++;
      if (mem_req) begin
        req_cyc++;
        if (!prev_req) n_fill++;
        if (seen_addr.size() == 0 || seen_addr[$] != mem_addr) seen_addr.push_back(mem_addr);
      end
      prev_req = mem_req;
      step();
    end
    chk("stall_released", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, n;
    logic [31:0] hit_exp [3];
    hit_exp[0] = 32'hA1;
    hit_exp[1] = 32'hA2;
    hit_exp[2] = 32'hA3;

    // Reset state
    repeat (3) step();
    chk("rst_stall",       {31'd0, stall}, 32'd0);
    chk("rst_mem_req",     {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr",    mem_addr, 32'h0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr_out",   instr_out, 32'h0);
    chk("rst_miss_count",  {16'd0, miss_count}, 32'd0);
    rst = 1'b0;
    step();

    // Cold miss on 0x10
    addr_in = 32'h10; fetch_en = 1'b1;
    step();
    chk("cold_lookup_stall", {31'd0, stall}, 32'd1);
    chk("cold_lookup_ivalid", {31'd0, instr_valid}, 32'd0);
    wait_fill(s, r, n);
    chk("cold_stall_cycles", s, 32'd6);
    chk("cold_req_cycles", r, 32'd4);
    chk("cold_addr_count", seen_addr.size(), 32'd4);
    chk("cold_addr0", seen_addr[0], 32'h10);
    chk("cold_addr1", seen_addr[1], 32'h14);
    chk("cold_addr2", seen_addr[2], 32'h18);
    chk("cold_addr3", seen_addr[3], 32'h1C);
    chk("cold_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("cold_instr", instr_out, 32'hA0);
    chk("cold_miss_count", {16'd0, miss_count}, 32'd1);

    // Hit streak 0x14, 0x18, 0x1C
    for (int i = 0; i < 3; i++) begin
      addr_in = 32'h14 + 32'(4 * i);
      step();
      chk("hit_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("hit_stall", {31'd0, stall}, 32'd0);
      chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
      chk("hit_instr", instr_out, hit_exp[i]);
    end

    // Conflict: 0x90 evicts 0x10, then 0x10 misses again
    addr_in = 32'h90;
    step();
    chk("conf_stall", {31'd0, stall}, 32'd1);
    wait_fill(s, r, n);
    chk("conf_first_addr", seen_addr[0], 32'h90);
    chk("conf_stall_cycles", s, 32'd6);
    chk("conf_instr", instr_out, 32'h8A0);
    chk("conf_miss_count", {16'd0, miss_count}, 32'd2);
    addr_in = 32'h10;
    step();
    chk("refetch_stall", {31'd0, stall}, 32'd1);
    wait_fill(s, r, n);
    chk("refetch_first_addr", seen_addr[0], 32'h10);
    chk("refetch_instr", instr_out, 32'hA0);
    chk("refetch_miss_count", {16'd0, miss_count}, 32'd3);

    // Slow memory: 5 waiting cycles per word
    mem_lat = 5;
    addr_in = 32'h20;
    step();
    chk("slow_stall", {31'd0, stall}, 32'd1);
    wait_fill(s, r, n);
    chk("slow_stall_cycles", s, 32'd26);
    chk("slow_req_cycles", r, 32'd24);
    chk("slow_fill_starts", n, 32'd1);
    chk("slow_addr_count", seen_addr.size(), 32'd4);
    chk("slow_addr3", seen_addr[3], 32'h2C);
    chk("slow_instr", instr_out, 32'h2A0);
    chk("slow_miss_count", {16'd0, miss_count}, 32'd4);

    // Idle lookup, then spurious ack with no request outstanding
    fetch_en = 1'b0;
    step();
    chk("idle_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("idle_instr", instr_out, 32'h0);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    spur_ack = 1'b1;
    step();
    step();
    spur_ack = 1'b0;
    chk("spur_mem_req", {31'd0, mem_req}, 32'd0);
    chk("spur_stall", {31'd0, stall}, 32'd0);
    chk("spur_miss_count", {16'd0, miss_count}, 32'd4);
    fetch_en = 1'b1; addr_in = 32'h24;
    step();
    chk("spur_hit_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("spur_hit_instr", instr_out, 32'h2A1);

    // Flush in LOOKUP: same-cycle hit still served, next fetch misses
    mem_lat = 0;
    addr_in = 32'h14;
    step();
    chk("preflush_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("preflush_instr", instr_out, 32'hA1);
    flush = 1'b1; addr_in = 32'h18;
    step();
    flush = 1'b0;
    chk("postflush_stall", {31'd0, stall}, 32'd1);
    chk("postflush_ivalid", {31'd0, instr_valid}, 32'd0);
    wait_fill(s, r, n);
    chk("postflush_instr", instr_out, 32'hA2);
    chk("postflush_miss_count", {16'd0, miss_count}, 32'd5);

    // Flush pulse during word 2 of a fill: line dropped at COMMIT, refilled
    mem_lat = 2;
    addr_in = 32'h30;
    step();
    chk("fflush_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 50 && !(mem_req && mem_addr == 32'h38); i++) step();
    chk("fflush_word2_addr", mem_addr, 32'h38);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_fill(s, r, n);
    chk("fflush_fill_starts", n, 32'd2);
    chk("fflush_miss_count", {16'd0, miss_count}, 32'd7);
    chk("fflush_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("fflush_instr", instr_out, 32'h2A0);

    // Reset during word 1 of a fill, late ack afterwards
    mem_lat = 3;
    addr_in = 32'h40;
    step();
    chk("rfill_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 50 && !(mem_req && mem_addr == 32'h44); i++) step();
    chk("rfill_word1_addr", mem_addr, 32'h44);
    rst = 1'b1;
    #1;
    chk("rfill_async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rfill_async_mem_addr", mem_addr, 32'h0);
    chk("rfill_async_stall", {31'd0, stall}, 32'd0);
    chk("rfill_async_miss_count", {16'd0, miss_count}, 32'd0);
    fetch_en = 1'b0;
    step();
    spur_ack = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    spur_ack = 1'b0;
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    chk("late_ack_miss_count", {16'd0, miss_count}, 32'd0);
    fetch_en = 1'b1; addr_in = 32'h10;
    step();
    chk("rfill_valid_cleared", {31'd0, stall}, 32'd1);
    wait_fill(s, r, n);
    chk("rfill_refill_instr", instr_out, 32'hA0);
    chk("rfill_miss_count", {16'd0, miss_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
